// File: rtl/alu_operand_stage.sv
// Operand pipeline register in front of the execute ALU: resolves rs/rt forwarding,
// selects the B source and holds A/B/S plus destination info under a valid/ready handshake.
module alu_operand_stage #(
    parameter int n = 32,
    parameter int r = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [r-1:0] rs_addr,
    input  logic [r-1:0] rt_addr,
    input  logic [n-1:0] rs_data,
    input  logic [n-1:0] rt_data,
    input  logic [15:0]  imm16,
    input  logic [4:0]   shamt,
    input  logic [1:0]   b_sel,
    input  logic [2:0]   alu_op,
    input  logic [r-1:0] rd_addr,
    input  logic         reg_write,
    input  logic [n-1:0] alu_y,
    input  logic         wb_valid,
    input  logic [r-1:0] wb_rd,
    input  logic [n-1:0] wb_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] A,
    output logic [n-1:0] B,
    output logic [2:0]   S,
    output logic [r-1:0] out_rd,
    output logic         out_reg_write
);

    logic         valid_reg;
    logic [n-1:0] a_reg;
    logic [n-1:0] b_reg;
    logic [2:0]   s_reg;
    logic [r-1:0] rd_reg;
    logic         reg_write_reg;

    logic         load;
    logic [n-1:0] rs_fwd;
    logic [n-1:0] rt_fwd;
    logic [n-1:0] b_next;

    // The held instruction's result (still on the ALU output) is newer than
    // anything in writeback, so it wins. Register 0 is never forwarded.
    function automatic logic [n-1:0] forward(
        input logic [r-1:0] addr,
        input logic [n-1:0] rf_data,
        input logic         held_valid,
        input logic         held_write,
        input logic [r-1:0] held_rd,
        input logic [n-1:0] held_y,
        input logic         wbv,
        input logic [r-1:0] wbrd,
        input logic [n-1:0] wbd
    );
        logic [n-1:0] result;
        result = rf_data;
        if (addr != '0) begin
            if (held_valid && held_write && (held_rd == addr)) begin
                result = held_y;
            end else if (wbv && (wbrd == addr)) begin
                result = wbd;
            end
        end
        return result;
    endfunction

    assign in_ready = !valid_reg || out_ready;
    assign load     = in_valid && in_ready && !flush;

    assign rs_fwd = forward(rs_addr, rs_data, valid_reg, reg_write_reg, rd_reg,
                            alu_y, wb_valid, wb_rd, wb_data);
    assign rt_fwd = forward(rt_addr, rt_data, valid_reg, reg_write_reg, rd_reg,
                            alu_y, wb_valid, wb_rd, wb_data);

    always_comb begin
        b_next = rt_fwd;
        case (b_sel)
            2'b00:   b_next = rt_fwd;
            2'b01:   b_next = {{(n-16){imm16[15]}}, imm16};
            2'b10:   b_next = {{(n-16){1'b0}}, imm16};
            2'b11:   b_next = {{(n-5){1'b0}}, shamt};
            default: b_next = rt_fwd;
        endcase
    end

    // A, B, S and out_rd only move on a load; valid and write-enable drop on
    // flush or drain so a bubble can never write the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            s_reg         <= '0;
            rd_reg        <= '0;
            reg_write_reg <= 1'b0;
        end else if (flush) begin
            valid_reg     <= 1'b0;
            reg_write_reg <= 1'b0;
        end else if (load) begin
            valid_reg     <= 1'b1;
            a_reg         <= rs_fwd;
            b_reg         <= b_next;
            s_reg         <= alu_op;
            rd_reg        <= rd_addr;
            reg_write_reg <= reg_write;
        end else if (valid_reg && out_ready) begin
            valid_reg     <= 1'b0;
            reg_write_reg <= 1'b0;
        end
    end

    assign out_valid     = valid_reg;
    assign A             = a_reg;
    assign B             = b_reg;
    assign S             = s_reg;
    assign out_rd        = rd_reg;
    assign out_reg_write = reg_write_reg;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline register stage directly upstream of the execute ALU.
- Accepts decoded instructions from the register-read stage.
- Resolves operand forwarding and immediate/shift-amount selection, then presents registered A, B and a 3-bit ALU select S to the ALU.
- Carries destination info alongside, using a valid/ready handshake with stall and flush.

Parameters:
- n, 32, datapath width of operands and results.
- r, 5, register address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can accept this cycle.
- rs_addr  input  r  source register 1 address.
- rt_addr  input  r  source register 2 address.
- rs_data  input  n  register file read data, port 1.
- rt_data  input  n  register file read data, port 2.
- imm16  input  16  instruction immediate.
- shamt  input  5  shift amount.
- b_sel  input  2  B source: 00 rt, 01 sign-extended imm16, 10 zero-extended imm16, 11 zero-extended shamt.
- alu_op  input  3  ALU select: 000 add, 001 sub, 010 or, 011 and, 100 sll, 101 srl, 110 nor, 111 slt.
- rd_addr  input  r  destination register.
- reg_write  input  1  instruction writes rd.
- alu_y  input  n  ALU result for the instruction currently held (combinational feedback).
- wb_valid  input  1  writeback stage writing this cycle.
- wb_rd  input  r  writeback destination.
- wb_data  input  n  writeback data.
- flush  input  1  discard held and incoming instruction.
- out_valid  output  1  A/B/S valid.
- out_ready  input  1  downstream accepts.
- A  output  n  ALU operand A.
- B  output  n  ALU operand B.
- S  output  3  ALU select.
- out_rd  output  r  destination of held instruction.
- out_reg_write  output  1  held instruction writes rd.

Behaviour:
- Reset: out_valid=0, A=0, B=0, S=000, out_rd=0, out_reg_write=0. in_ready=1 in the cycle after reset deasserts.
- in_ready = !out_valid || out_ready. It is combinational and independent of in_valid.
- Load: when in_valid && in_ready && !flush, all outputs are registered on the next rising edge and out_valid=1. Latency is 1 cycle.
- Hold: when out_valid && !out_ready, all outputs hold their values. No field may change while out_valid=1 and out_ready=0.
- Drain: when out_ready && out_valid && !(in_valid && !flush), out_valid goes to 0. A, B and S hold their last values.
- Flush: flush=1 forces out_valid=0 and out_reg_write=0 on the next edge, regardless of in_valid, out_ready or stall. Flush has priority over load.
- Reset has priority over flush.
- Forwarding is evaluated on the load cycle, separately for the rs and rt operands. Priority, highest first:
  1. alu_y, if out_valid && out_reg_write && out_rd==addr && addr!=0.
  2. wb_data, if wb_valid && wb_rd==addr && addr!=0.
  3. Register file data.
- Address 0 is never forwarded. The selected rs/rt value passes through unchanged, even if nonzero.
- A = forwarded rs value.
- B is chosen by b_sel:
  - 00: forwarded rt value.
  - 01: {{(n-16){imm16[15]}},imm16}.
  - 10: {(n-16)'b0,imm16}.
  - 11: {(n-5)'b0,shamt}.
- Shifts (alu_op 100/101) use A as the value and B as the amount. The decoder supplies rt on rs_addr/rs_data for sll/srl; this stage does no operand swapping.
- S = alu_op, registered.
- out_rd and out_reg_write are registered alongside. out_reg_write is gated by the load, so a bubble never writes.
- Simultaneous drain+load (out_valid && out_ready && in_valid): the new instruction replaces the old one in the same edge with no bubble, and it may forward the departing alu_y.
- Stalled incoming instruction (in_ready=0): the stage does not sample it. Upstream holds all inputs stable until accepted.

Test Plan:
- Reset, then load add with rs=1 (0x5), rt=2 (0x7), b_sel=00 -> next cycle out_valid=1, A=0x5, B=0x7, S=000, out_rd as given.
- b_sel=01 with imm16=0xFFFE -> B=0xFFFFFFFE. b_sel=10 with imm16=0xFFFE -> B=0x0000FFFE. b_sel=11 with shamt=3, op 100 -> B=0x3, S=100.
- Back-to-back dependency: held instruction has rd=3, alu_y=0x10, and the incoming instruction has rs=3, rs_data=0xDEAD. Also set wb_rd=3, wb_data=0x20 -> A=0x10 (ALU forward wins). With out_reg_write=0 -> A=0x20. With rs_addr=0 -> A=rs_data.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and A/B/S/out_rd are unchanged for 3 cycles. On release, the next instruction loads in the same edge the old one leaves, with no bubble.
- flush=1 asserted while stalled and in_valid=1 -> next cycle out_valid=0 and out_reg_write=0, and the incoming instruction is not captured. The following cycle in_ready=1.
- Assert reset mid-stall with out_valid=1 -> next edge all outputs are zero and out_valid=0. The stage loads normally the cycle after reset is released.
